// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall/flush sequencer: arbitrates memory stalls, debug halt,
// control hazards and load-use hazards into per-stage register enables.
// Optional stall performance counter: define PIPELINE_STALL_SEQUENCER_PERF_EN.
module pipeline_stall_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load_inst,
    input  logic             ex_rf_enable,
    input  logic             control_hazard,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_load_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             control_nop,
    output logic             if_id_flush,
    output logic             mem_fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned NUM_STG  = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NUM_STG-1:0]  en;
    logic                memstall;
    logic                load_use;

    assign memstall = mem_access & ~mem_ready;
    assign load_use = ex_load_inst & ex_rf_enable & (ex_rd != 5'd0) &
                      ((ex_rd == id_rn) | (ex_rd == id_rm));

    // State and wait-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and combinational stage-control decode
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        en          = '1;
        control_nop = 1'b0;
        if_id_flush = 1'b0;
        mem_fault   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (memstall) begin
                    en         = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    if (control_hazard) begin
                        if_id_flush = 1'b1;
                        control_nop = 1'b1;
                    end else if (load_use) begin
                        en[4]       = 1'b0;
                        en[3]       = 1'b0;
                        control_nop = 1'b1;
                    end
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (memstall) begin
                    en = '0;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = halt_req ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                en = '0;
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                en        = '0;
                mem_fault = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_load_enable = en[4];
    assign if_id_enable   = en[3];
    assign id_ex_enable   = en[2];
    assign ex_mem_enable  = en[1];
    assign mem_wb_enable  = en[0];
    assign state          = state_q;

`ifdef PIPELINE_STALL_SEQUENCER_PERF_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of edges where the PC is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_load_enable && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed self-checking bench for pipeline_stall_sequencer.
module tb_pipeline_stall_sequencer;

    localparam int unsigned CNT_W = 16;
`ifdef PIPELINE_STALL_SEQUENCER_PERF_EN
    localparam int unsigned EXP_MEM_STALLS = 4;
`else
    localparam int unsigned EXP_MEM_STALLS = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rn, id_rm, ex_rd;
    logic             ex_load_inst, ex_rf_enable, control_hazard;
    logic             mem_access, mem_ready, halt_req;
    logic             pc_load_enable, if_id_enable, id_ex_enable;
    logic             ex_mem_enable, mem_wb_enable;
    logic             control_nop, if_id_flush, mem_fault;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [4:0]       en;

    int checks = 0;
    int errors = 0;

    pipeline_stall_sequencer #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rn          (id_rn),
        .id_rm          (id_rm),
        .ex_rd          (ex_rd),
        .ex_load_inst   (ex_load_inst),
        .ex_rf_enable   (ex_rf_enable),
        .control_hazard (control_hazard),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .halt_req       (halt_req),
        .pc_load_enable (pc_load_enable),
        .if_id_enable   (if_id_enable),
        .id_ex_enable   (id_ex_enable),
        .ex_mem_enable  (ex_mem_enable),
        .mem_wb_enable  (mem_wb_enable),
        .control_nop    (control_nop),
        .if_id_flush    (if_id_flush),
        .mem_fault      (mem_fault),
        .state          (state),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    assign en = {pc_load_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns just after the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        ex_load_inst = 1'b0; ex_rf_enable = 1'b0; control_hazard = 1'b0;
        mem_access = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_en", 32'(en), 32'h1f);
        check_eq("rst_nop_flush", 32'({control_nop, if_id_flush}), 32'd0);
        check_eq("rst_fault", 32'(mem_fault), 32'd0);
        check_eq("rst_stalls", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Load-use on id_rn
        ex_load_inst = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd5; id_rn = 5'd5; id_rm = 5'd9;
        #1;
        check_eq("lu_en", 32'(en), 32'h07);
        check_eq("lu_nop", 32'(control_nop), 32'd1);
        check_eq("lu_flush", 32'(if_id_flush), 32'd0);
        // Load-use on id_rm
        id_rn = 5'd3; id_rm = 5'd5;
        #1;
        check_eq("lu_rm_en", 32'(en), 32'h07);
        // Not a register-file write: no hazard
        ex_rf_enable = 1'b0;
        #1;
        check_eq("lu_norf_en", 32'(en), 32'h1f);
        // Destination x0: no hazard
        ex_rf_enable = 1'b1; ex_rd = 5'd0; id_rn = 5'd0;
        #1;
        check_eq("lu_x0_en", 32'(en), 32'h1f);
        check_eq("lu_x0_nop", 32'(control_nop), 32'd0);
        // Control hazard overrides load-use
        ex_rd = 5'd5; id_rn = 5'd5; control_hazard = 1'b1;
        #1;
        check_eq("ch_en", 32'(en), 32'h1f);
        check_eq("ch_flush_nop", 32'({if_id_flush, control_nop}), 32'h3);
        check_eq("ch_state", 32'(state), 32'd0);

        // Memory wait: 1 RUN stall cycle, 3 MEM_WAIT stall cycles, then ready
        clear_inputs();
        @(negedge clk);
        pulse_reset();
        mem_access = 1'b1;
        #1;
        check_eq("mw_run_en", 32'(en), 32'h00);
        check_eq("mw_run_nop_flush", 32'({control_nop, if_id_flush}), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("mw_state", 32'(state), 32'd1);
            check_eq("mw_en", 32'(en), 32'h00);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("mw_ready_state", 32'(state), 32'd1);
        check_eq("mw_ready_en", 32'(en), 32'h1f);
        step();
        mem_access = 1'b0; mem_ready = 1'b0;
        #1;
        check_eq("mw_done_state", 32'(state), 32'd0);
        check_eq("mw_stalls", 32'(stall_cycles), 32'(EXP_MEM_STALLS));

        // Timeout into FAULT after 8 MEM_WAIT cycles
        pulse_reset();
        mem_access = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            control_hazard = (i == 2);
            ex_load_inst = (i == 3); ex_rf_enable = (i == 3); ex_rd = 5'd4; id_rn = 5'd4;
            #1;
            check_eq("to_wait_state", 32'(state), 32'd1);
            check_eq("to_wait_ctl", 32'({en, control_nop, if_id_flush}), 32'd0);
            step();
        end
        check_eq("to_state", 32'(state), 32'd3);
        check_eq("to_fault", 32'(mem_fault), 32'd1);
        check_eq("to_en", 32'(en), 32'h00);
        clear_inputs();
        step();
        check_eq("to_sticky", 32'({state, mem_fault}), 32'h7);
        pulse_reset();
        check_eq("to_rst_state", 32'(state), 32'd0);
        check_eq("to_rst_fault", 32'(mem_fault), 32'd0);
        check_eq("to_rst_en", 32'(en), 32'h1f);

        // Halt requested during MEM_WAIT
        @(negedge clk);
        mem_access = 1'b1;
        step();
        halt_req = 1'b1;
        #1;
        check_eq("hw_wait_state", 32'(state), 32'd1);
        check_eq("hw_wait_en", 32'(en), 32'h00);
        step();
        mem_ready = 1'b1;
        #1;
        check_eq("hw_ready_en", 32'(en), 32'h1f);
        step();
        mem_access = 1'b0; mem_ready = 1'b0;
        #1;
        check_eq("hw_halt_state", 32'(state), 32'd2);
        check_eq("hw_halt_en", 32'(en), 32'h00);
        step();
        check_eq("hw_hold_state", 32'(state), 32'd2);
        halt_req = 1'b0;
        #1;
        check_eq("hw_release_en", 32'(en), 32'h00);
        step();
        check_eq("hw_run_state", 32'(state), 32'd0);
        check_eq("hw_run_en", 32'(en), 32'h1f);

        // Halt from RUN: pipeline advances that cycle
        halt_req = 1'b1;
        #1;
        check_eq("hr_en", 32'(en), 32'h1f);
        step();
        check_eq("hr_state", 32'(state), 32'd2);
        check_eq("hr_halt_en", 32'(en), 32'h00);
        halt_req = 1'b0;
        step();
        check_eq("hr_back_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_sequencer.md
PIPELINE_STALL_SEQUENCER -- requirements
Module: pipeline_stall_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 8, the maximum number of MEM_WAIT cycles before a fault.
REQ-003 The block SHALL have parameter CNT_W, default 16, the stall counter width.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- id_rn, id_rm  in  5 each  ID-stage source registers
- ex_rd  in  5  EX-stage destination register
- ex_load_inst, ex_rf_enable  in  1 each  EX is a load; EX writes the register file
- control_hazard  in  1  branch or jump taken in EX
- mem_access  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes this cycle
- halt_req  in  1  debug halt request (level)
- pc_load_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1 each  stage register enables
- control_nop  out  1  inject a NOP into ID/EX
- if_id_flush  out  1  clear IF/ID
- mem_fault  out  1  sticky memory timeout flag
- state  out  2  FSM state
- stall_cycles  out  CNT_W  stall counter

Function
REQ-005 The FSM SHALL use these state encodings: RUN=00, MEM_WAIT=01, HALT=10, FAULT=11.
REQ-006 memstall SHALL be defined as mem_access & ~mem_ready, evaluated in RUN or MEM_WAIT.
- memstall=1: all five enables 0, control_nop 0, if_id_flush 0.
- This takes effect in the same cycle, combinationally.
REQ-007 In RUN, memstall SHALL transition the FSM to MEM_WAIT.
REQ-008 In MEM_WAIT, a wait counter SHALL count stall cycles.
- mem_ready=1: the enables are restored that cycle; next state is HALT if halt_req=1, otherwise RUN.
- MEM_WAIT cycle count reaches MEM_TIMEOUT with mem_ready=0: next state is FAULT.
REQ-009 In RUN with memstall=0 and halt_req=1, the pipeline SHALL advance that cycle and the next state SHALL be HALT.
REQ-010 In HALT, all enables SHALL be 0; halt_req=0 SHALL return the FSM to RUN on the next edge.
REQ-011 FAULT SHALL drive all enables 0 and mem_fault=1, and only reset SHALL exit it.
REQ-012 Load-use hazard SHALL be defined as ex_load_inst & ex_rf_enable & ex_rd!=0 & (ex_rd==id_rn | ex_rd==id_rm).
- In RUN with memstall=0, a load-use hazard drives pc_load_enable=0, if_id_enable=0, control_nop=1, and the remaining enables 1.
REQ-013 In RUN with memstall=0 and control_hazard=1, the outputs SHALL be if_id_flush=1, control_nop=1, all enables 1.
- control_hazard overrides a load-use hazard in the same cycle.
REQ-014 In RUN with no hazard, the outputs SHALL be all enables 1, control_nop 0, if_id_flush 0.
REQ-015 Priority SHALL be FAULT > HALT > memstall > control_hazard > load-use.
REQ-016 control_hazard and load-use SHALL be ignored in the MEM_WAIT, HALT and FAULT states.
REQ-017 The wait counter SHALL clear on every entry to MEM_WAIT.

Reset
REQ-018 Asserting reset at any time SHALL asynchronously force:
- state=RUN, wait counter 0, mem_fault=0, stall_cycles=0;
- all enables=1, control_nop=0, if_id_flush=0.
REQ-019 Reset asserted during MEM_WAIT or FAULT SHALL abandon the operation with no residual state.

Configuration
REQ-020 With macro PIPELINE_STALL_SEQUENCER_PERF_EN defined:
- stall_cycles increments on each clock edge where pc_load_enable=0.
- It saturates at all ones.
REQ-021 Without PIPELINE_STALL_SEQUENCER_PERF_EN, the stall_cycles port SHALL still exist and SHALL be driven constant 0.

Verification
REQ-022 Load-use scenario: ex_load_inst=1, ex_rf_enable=1, ex_rd=5, id_rn=5 in RUN -> pc_load_enable=0, if_id_enable=0, control_nop=1, id_ex_enable=1 that cycle.
REQ-023 Load-use to x0: same as REQ-022 with ex_rd=0, id_rn=0 -> no stall, all enables 1.
REQ-024 Flush over load-use: control_hazard=1 with the REQ-022 load-use conditions -> if_id_flush=1, control_nop=1, pc_load_enable=1.
REQ-025 Memory wait: mem_access=1 with mem_ready=0 for 3 cycles, then 1 -> state 01 for 3 cycles, enables 0, RUN afterwards; stall_cycles=4 with the macro, 0 without.
REQ-026 Timeout: mem_access=1 with mem_ready held 0 -> state=11 and mem_fault=1 after 8 MEM_WAIT cycles; reset pulse -> state=00, mem_fault=0.
REQ-027 Halt during wait: halt_req=1 raised during MEM_WAIT -> HALT after mem_ready; halt_req=0 -> RUN on the next edge.
